// File: rtl/mgmt_gpio_in_sync.sv
// mgmt_gpio_in_sync: per-bit 2-flop sync, optional debounce and edge-triggered sticky interrupts.
// Define MGMT_GPIO_DEBOUNCE_EN to enable the DEBOUNCE_CYC stability filter.
module mgmt_gpio_in_sync #(
   parameter int NPADS        = 19,
   parameter int DEBOUNCE_CYC = 4,
   parameter int CNT_W        = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [NPADS-1:0] gpio_in_buf,
   input  logic [NPADS-1:0] irq_en,
   input  logic [NPADS-1:0] irq_rise,
   input  logic [NPADS-1:0] irq_clr,
   output logic [NPADS-1:0] gpio_in_sync,
   output logic [NPADS-1:0] irq_pending,
   output logic             irq
);
   logic [NPADS-1:0] s1, s2, upd, evt;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= gpio_in_buf;
         s2 <= s1;
      end

`ifdef MGMT_GPIO_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);
   logic [CNT_W-1:0] cnt [NPADS];

   always_comb
      for (int i = 0; i < NPADS; i++)
         upd[i] = (s2[i] != gpio_in_sync[i]) && (cnt[i] == LAST);

   // count restarts whenever s2 agrees with the accepted level or a new level is taken
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      for (int i = 0; i < NPADS; i++)
         if (wb_rst_i) cnt[i] <= '0;
         else cnt[i] <= (s2[i] == gpio_in_sync[i] || upd[i]) ? '0 : cnt[i] + CNT_W'(1);
`else
   assign upd = s2 ^ gpio_in_sync;
`endif

   // an accepted change to 1 is a rise, to 0 a fall; match it against the edge select
   assign evt = upd & irq_en & ~(irq_rise ^ s2);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         gpio_in_sync <= '0;
         irq_pending  <= '0;
      end else begin
         gpio_in_sync <= (gpio_in_sync & ~upd) | (s2 & upd);
         irq_pending  <= evt | (irq_pending & ~irq_clr);
      end

   assign irq = |irq_pending;
endmodule

// File: tb/tb_mgmt_gpio_in_sync.sv
// tb_mgmt_gpio_in_sync: scoreboard bench; expected outputs are queued per edge from a
// history-based reference model and compared one time unit after each rising edge.
module tb_mgmt_gpio_in_sync;
   localparam int N = 19;
   localparam int D = 4;
`ifdef MGMT_GPIO_DEBOUNCE_EN
   localparam int LAT = 2 + D;
   localparam logic GLITCH_PASS = 1'b0;
`else
   localparam int LAT = 3;
   localparam logic GLITCH_PASS = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] pad = '0, en = '0, rise = '0, clr = '0;
   logic [N-1:0] gpio_in_sync, irq_pending;
   logic irq;

   typedef struct packed {
      logic [N-1:0] sync;
      logic [N-1:0] pend;
      logic         irq;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   string phase = "init";

   logic [N-1:0] m_s1 = '0, m_s2 = '0, m_sync = '0, m_pend = '0;
   logic [D-1:0] m_hist [N];

   mgmt_gpio_in_sync #(.NPADS(N), .DEBOUNCE_CYC(D), .CNT_W(8)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .gpio_in_buf(pad),
      .irq_en(en),
      .irq_rise(rise),
      .irq_clr(clr),
      .gpio_in_sync(gpio_in_sync),
      .irq_pending(irq_pending),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s.%s got=%h expected=%h", phase, tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_s1 = '0;
      m_s2 = '0;
      m_sync = '0;
      m_pend = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
   endtask

   // Advance the reference model by one rising edge using the currently driven inputs.
   task automatic model_edge();
      logic diff, upd, evt;
      if (rst) begin
         model_clear();
         return;
      end
      for (int i = 0; i < N; i++) begin
         diff = m_s2[i] ^ m_sync[i];
`ifdef MGMT_GPIO_DEBOUNCE_EN
         m_hist[i] = diff ? {m_hist[i][D-2:0], 1'b1} : '0;
         upd = &m_hist[i];
         if (upd) m_hist[i] = '0;
`else
         upd = diff;
`endif
         evt = upd & en[i] & (rise[i] ? m_s2[i] : ~m_s2[i]);
         if (upd) m_sync[i] = m_s2[i];
         m_pend[i] = evt | (m_pend[i] & ~clr[i]);
      end
      m_s2 = m_s1;
      m_s1 = pad;
   endtask

   task automatic step(input int n);
      exp_t e;
      repeat (n) begin
         model_edge();
         sb.push_back('{m_sync, m_pend, |m_pend});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check("sync", gpio_in_sync, e.sync);
         check("pend", irq_pending, e.pend);
         check("irq", irq, e.irq);
      end
   endtask

   task automatic hit_reset();
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check("rst_sync", gpio_in_sync, 0);
      check("rst_pend", irq_pending, 0);
      check("rst_irq", irq, 0);
   endtask

   task automatic clear_all();
      clr = '1;
      step(1);
      clr = '0;
   endtask

   initial begin
      int lat;
      logic hi;
      model_clear();

      phase = "reset";
      pad = '1;
      step(3);
      check("hold_sync", gpio_in_sync, 0);
      check("hold_irq", irq, 0);
      rst = 1'b0;
      step(LAT + 3);
      check("settle_hi", gpio_in_sync, {N{1'b1}});
      pad = '0;
      step(LAT + 3);

      phase = "rise";
      en[0] = 1'b1;
      rise[0] = 1'b1;
      pad[0] = 1'b1;
      lat = 0;
      for (int k = 1; k <= LAT + 3; k++) begin
         step(1);
         if (gpio_in_sync[0] && lat == 0) lat = k;
      end
      check("latency", lat, LAT);
      check("pend0", irq_pending[0], 1);
      check("irq", irq, 1);

      phase = "glitch";
      en[3] = 1'b1;
      rise[3] = 1'b1;
      pad[3] = 1'b1;
      hi = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         hi |= gpio_in_sync[3];
      end
      pad[3] = 1'b0;
      for (int k = 0; k < LAT + 3; k++) begin
         step(1);
         hi |= gpio_in_sync[3];
      end
      check("seen", hi, GLITCH_PASS);
      check("pend3", irq_pending[3], GLITCH_PASS);
      clear_all();

      phase = "fall";
      en[5] = 1'b1;
      rise[5] = 1'b0;
      pad[5] = 1'b1;
      step(LAT + 3);
      check("no_rise", irq_pending[5], 0);
      pad[5] = 1'b0;
      step(LAT + 3);
      check("pend5", irq_pending[5], 1);
      clear_all();
      en[5] = 1'b0;
      pad[5] = 1'b1;
      step(LAT + 3);
      check("follow_hi", gpio_in_sync[5], 1);
      pad[5] = 1'b0;
      step(LAT + 3);
      check("dis_pend5", irq_pending[5], 0);
      check("follow_lo", gpio_in_sync[5], 0);

      phase = "collide";
      pad[0] = 1'b0;
      step(LAT + 3);
      clear_all();
      pad[0] = 1'b1;
      step(LAT - 1);
      clr[0] = 1'b1;
      step(1);
      clr[0] = 1'b0;
      check("set_wins", irq_pending[0], 1);
      clr[0] = 1'b1;
      step(1);
      clr[0] = 1'b0;
      check("cleared", irq_pending[0], 0);
      check("irq_low", irq, 0);
      clr[7] = 1'b1;
      step(1);
      clr[7] = 1'b0;
      check("idle_clr", irq_pending, 0);

      phase = "rstmid";
      pad[0] = 1'b0;
      step(LAT + 3);
      clear_all();
      pad[0] = 1'b1;
      step(4);
      hit_reset();
      step(2);
      rst = 1'b0;
      lat = 0;
      for (int k = 1; k <= LAT + 3; k++) begin
         step(1);
         if (gpio_in_sync[0] && lat == 0) lat = k;
      end
      check("latency", lat, LAT);

      phase = "rand";
      for (int k = 0; k < 400; k++) begin
         pad ^= N'($urandom & $urandom & $urandom);
         en = N'($urandom);
         rise = N'($urandom);
         clr = N'($urandom & $urandom & $urandom);
         step(1);
      end
      clr = '0;
      hit_reset();
      step(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
